// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the display driver and this receiver.
// Contents:
//   SEG_0..SEG_F, SEG_BLANK  active-low segment codes, bit0=a .. bit6=g
//   SEG_CODES                the 16 digit codes indexed by hex value
//   state_t                  receiver FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h58;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODES [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no digit seen since reset
    LIT  = 2'd1,  // a digit is currently displayed
    DARK = 2'd2   // display blanked after a digit was shown
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier for one active-low segment pattern.
// Ports:
//   seg       in   7  segment pattern, active-low, bit0=a .. bit6=g
//   is_digit  out  1  pattern is one of the 16 hex digit codes
//   is_blank  out  1  pattern is all segments off (7'h7F)
//   hex       out  4  hex value of the pattern (0 when not a digit)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] hex
);

  logic [15:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (seg == SEG_CODES[gi]);
    end
  endgenerate

  // Codes are unique, so at most one hit bit is set.
  always_comb begin
    hex = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) hex = 4'(i);
    end
  end

  assign is_digit = |hit;
  assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_blink_decoder.sv
// Receiver for an active-low 7-segment bus: recovers the shown hex digit and
// detects blinking by timing the lit/dark phases.
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   seg          in   7      segment bus, active-low, bit0=a .. bit6=g
//   digit        out  4      last accepted hex digit (held through dark phases)
//   digit_valid  out  1      a digit has been accepted since reset
//   blank        out  1      currently in the dark phase
//   blinking     out  1      at least two short phases in a row on this digit
//   invalid      out  1      one-cycle pulse for an accepted non-digit, non-blank pattern
//   half_period  out  CNT_W  length of the last completed lit/dark phase
module seg7_blink_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int BLINK_MAX  = 2_000_000,
  parameter int CNT_W      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             blinking,
  output logic             invalid,
  output logic [CNT_W-1:0] half_period
);

  localparam int              SW        = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0]   STAB_MAX  = SW'(STABLE_CYC);
  localparam logic [CNT_W-1:0] PH_LIMIT = CNT_W'(BLINK_MAX);
  localparam logic [CNT_W-1:0] PH_SAT   = CNT_W'(BLINK_MAX + 1);

  // ---------------- sampler / stability filter ----------------
  logic [6:0]    sample_reg;
  logic [SW-1:0] stab_cnt_reg;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_reg   <= SEG_BLANK;
      stab_cnt_reg <= '0;
    end else begin
      sample_reg <= seg;
      if (seg != sample_reg)
        stab_cnt_reg <= '0;
      else if (stab_cnt_reg != STAB_MAX)
        stab_cnt_reg <= stab_cnt_reg + 1'b1;
    end
  end

  // Fires on the edge where the counter steps onto STABLE_CYC; saturation
  // then keeps it from firing again for the same stable run.
  assign accept = (seg == sample_reg) && (stab_cnt_reg == STAB_LAST);

  logic       pat_digit;
  logic       pat_blank;
  logic [3:0] pat_hex;

  seg7_pattern_decode u_decode (
    .seg      (sample_reg),
    .is_digit (pat_digit),
    .is_blank (pat_blank),
    .hex      (pat_hex)
  );

  // ---------------- FSM and phase/toggle counters ----------------
  state_t           state_reg, state_next;
  logic [3:0]       digit_reg, digit_next;
  logic             valid_reg, valid_next;
  logic [1:0]       tog_cnt_reg, tog_cnt_next;
  logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic [CNT_W-1:0] half_period_reg, half_period_next;
  logic             invalid_reg, invalid_next;
  logic             toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      digit_reg       <= 4'h0;
      valid_reg       <= 1'b0;
      tog_cnt_reg     <= 2'd0;
      phase_cnt_reg   <= '0;
      half_period_reg <= '0;
      invalid_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      digit_reg       <= digit_next;
      valid_reg       <= valid_next;
      tog_cnt_reg     <= tog_cnt_next;
      phase_cnt_reg   <= phase_cnt_next;
      half_period_reg <= half_period_next;
      invalid_reg     <= invalid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    digit_next       = digit_reg;
    valid_next       = valid_reg;
    tog_cnt_next     = tog_cnt_reg;
    phase_cnt_next   = phase_cnt_reg;
    half_period_next = half_period_reg;
    invalid_next     = 1'b0;
    toggle           = 1'b0;

    // Phase timing runs every cycle once a digit has been seen. The edge that
    // carries the counter past BLINK_MAX marks the phase as too long to be a
    // blink; an accept on the same edge may override this below.
    if (state_reg != IDLE) begin
      if (phase_cnt_reg != PH_SAT)
        phase_cnt_next = phase_cnt_reg + 1'b1;
      if (phase_cnt_reg == PH_LIMIT)
        tog_cnt_next = 2'd0;
    end

    if (accept) begin
      if (!pat_digit && !pat_blank) begin
        invalid_next = 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (pat_digit) begin
              state_next     = LIT;
              digit_next     = pat_hex;
              valid_next     = 1'b1;
              phase_cnt_next = '0;
            end
          end
          LIT: begin
            if (pat_blank) begin
              state_next = DARK;
              toggle     = 1'b1;
            end else if (pat_hex != digit_reg) begin
              // A new digit starts a fresh blink history.
              digit_next     = pat_hex;
              tog_cnt_next   = 2'd0;
              phase_cnt_next = '0;
            end
          end
          DARK: begin
            if (pat_digit) begin
              state_next = LIT;
              toggle     = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end

    if (toggle) begin
      half_period_next = phase_cnt_reg;
      phase_cnt_next   = '0;
      if (phase_cnt_reg <= PH_LIMIT)
        tog_cnt_next = (tog_cnt_reg == 2'd3) ? 2'd3 : tog_cnt_reg + 2'd1;
      else
        tog_cnt_next = 2'd1;  // long phase: only this transition counts
      // Coming out of DARK with a different digit restarts the history.
      if ((state_reg == DARK) && (pat_hex != digit_reg)) begin
        digit_next   = pat_hex;
        tog_cnt_next = 2'd0;
      end
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = valid_reg;
  assign blank       = (state_reg == DARK);
  assign blinking    = tog_cnt_reg[1];
  assign invalid     = invalid_reg;
  assign half_period = half_period_reg;

endmodule

// File: tb/tb_seg7_blink_decoder.sv
// Scoreboard bench for seg7_blink_decoder. The stimulus process drives one seg
// value per cycle, runs an event-level reference model and queues the expected
// outputs; the monitor pops one entry after every rising edge and compares.
module tb_seg7_blink_decoder;

  localparam int STABLE_CYC = 2;
  localparam int BLINK_MAX  = 20;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       seg = 7'h7F;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             blank;
  logic             blinking;
  logic             invalid;
  logic [CNT_W-1:0] half_period;

  always #5 clk = ~clk;

  seg7_blink_decoder #(
    .STABLE_CYC (STABLE_CYC),
    .BLINK_MAX  (BLINK_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .blinking    (blinking),
    .invalid     (invalid),
    .half_period (half_period)
  );

  typedef struct packed {
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             blinking;
    logic             invalid;
    logic [CNT_W-1:0] half_period;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [6:0] ref_codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- reference model (event/time based) ----------------
  logic [6:0] m_last;
  int m_run, m_now, m_start, m_toggles, m_hp, m_digit;
  bit m_started, m_dark;

  task automatic model_reset();
    m_last = 7'h7F; m_run = 1;   // the reset sample counts as one presentation
    m_now = 0; m_start = 0; m_toggles = 0; m_hp = 0; m_digit = 0;
    m_started = 0; m_dark = 0;
  endtask

  // -1: not a valid pattern, 0..15: hex digit, 16: blank
  function automatic int ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (ref_codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [6:0] s, output obs_t e);
    int  code, d, len;
    bit  inv, toggled, restarted, in_phase;
    inv = 0; toggled = 0; restarted = 0;
    m_now++;
    in_phase = m_started;
    d = m_now - m_start;               // cycles since this phase began
    if (s == m_last) m_run++;
    else begin m_last = s; m_run = 1; end
    if (m_run == STABLE_CYC + 1) begin
      code = ref_decode(s);
      if (code < 0) inv = 1;
      else if (!m_started) begin
        if (code < 16) begin
          m_started = 1; m_dark = 0; m_digit = code; m_start = m_now;
        end
      end else if ((!m_dark && code == 16) || (m_dark && code < 16)) begin
        toggled = 1;
        len = d - 1;
        m_hp = (len > BLINK_MAX + 1) ? BLINK_MAX + 1 : len;
        if (len <= BLINK_MAX) m_toggles++; else m_toggles = 1;
        m_start = m_now;
        m_dark = !m_dark;
        if (code < 16 && code != m_digit) begin
          m_digit = code; m_toggles = 0;
        end
      end else if (!m_dark && code != m_digit) begin
        restarted = 1; m_digit = code; m_toggles = 0; m_start = m_now;
      end
    end
    if (in_phase && !toggled && !restarted && d == BLINK_MAX + 1) m_toggles = 0;
    e.digit       = 4'(m_digit);
    e.digit_valid = m_started;
    e.blank       = m_dark;
    e.blinking    = (m_toggles >= 2);
    e.invalid     = inv;
    e.half_period = CNT_W'(m_hp);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic hold(input logic [6:0] s, input int n);
    obs_t e;
    $display("hold seg=%02h for %0d cycles", s, n);
    for (int i = 0; i < n; i++) begin
      seg = s;
      model_step(s, e);
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({digit, digit_valid, blank, blinking, invalid, half_period} !== '0) begin
      miscompares++;
      $display("FAIL %s: got digit=%h valid=%b blank=%b blinking=%b invalid=%b hp=%0d, want all zero",
               name, digit, digit_valid, blank, blinking, invalid, half_period);
    end
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check_reset_outputs(name);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = '{digit, digit_valid, blank, blinking, invalid, half_period};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL cycle %0t: got digit=%h valid=%b blank=%b blink=%b inv=%b hp=%0d, want digit=%h valid=%b blank=%b blink=%b inv=%b hp=%0d",
                   $time, act.digit, act.digit_valid, act.blank, act.blinking, act.invalid, act.half_period,
                   e.digit, e.digit_valid, e.blank, e.blinking, e.invalid, e.half_period);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [6:0] c;
    model_reset();
    @(negedge clk);
    check_reset_outputs("power-on reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: first digit after reset
    hold(7'h24, 6);
    // 2: sweep all codes
    for (int i = 0; i < 16; i++) hold(ref_codes[i], 10);
    // 3: blink digit 3 with 10-cycle phases
    hold(7'h30, 10);
    for (int i = 0; i < 3; i++) begin
      hold(7'h7F, 10);
      hold(7'h30, 10);
    end
    // 4: steady digit drops blinking after BLINK_MAX+1 cycles
    hold(7'h30, 30);
    // phases right at the limit: 21 cycles still counts, 22 does not
    hold(7'h7F, 21);
    hold(7'h30, 21);
    hold(7'h7F, 22);
    hold(7'h30, 10);
    // 5: glitch and invalid pattern
    hold(7'h79, 8);
    hold(7'h00, 1);
    hold(7'h79, 8);
    hold(7'h55, 5);
    hold(7'h79, 8);
    // 6: reset in the middle of a dark phase, then recover
    hold(7'h30, 10);
    hold(7'h7F, 10);
    hold(7'h30, 10);
    hold(7'h7F, 5);
    do_reset("reset during dark");
    hold(7'h24, 6);

    // randomized phases around the blink limit, plus short and junk patterns
    for (int r = 0; r < 60; r++) begin
      k = int'($urandom_range(0, 9));
      c = ref_codes[$urandom_range(0, 15)];
      if (k < 6) begin
        hold(c, int'($urandom_range(3, 26)));
        hold(7'h7F, int'($urandom_range(3, 26)));
      end else if (k < 8) begin
        hold(c, int'($urandom_range(1, 12)));
      end else begin
        hold(7'($urandom), int'($urandom_range(1, 6)));
      end
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
